tag_lookup_nway: RTL and testbench
==================================

TAG_LOOKUP_NWAY -- requirements
Module: tag_lookup_nway

Interface
REQ-001 SHALL have parameter WAYS, default 2, associativity; power of two, 2..8.
REQ-002 SHALL have parameter SETS, default 8, number of sets; power of two, 2..256.
REQ-003 SHALL have parameter TAG_W, default 9, tag width in bits.
REQ-004 SHALL derive localparams IDX_W = log2(SETS) and WAY_W = log2(WAYS).
REQ-005 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  lookup request.
- req_index  in  IDX_W  lookup set.
- req_tag  in  TAG_W  lookup tag.
- req_ready  out  1  lookup accepted when req_valid && req_ready.
- resp_valid  out  1  registered lookup result valid.
- resp_hit  out  1  lookup hit.
- resp_way  out  WAY_W  hitting way; 0 on miss.
- resp_victim  out  WAY_W  replacement way for the looked-up set.
- fill_valid  in  1  write tag into a way and set valid.
- fill_index  in  IDX_W  fill set.
- fill_way  in  WAY_W  fill way.
- fill_tag  in  TAG_W  fill tag.
- inval_valid  in  1  clear valid of one way.
- inval_index  in  IDX_W  invalidate set.
- inval_way  in  WAY_W  invalidate way.
- flush_start  in  1  start sweep clearing all sets.
- busy  out  1  flush in progress.
- flush_done  out  1  one-cycle pulse on the last flush cycle.

Function
REQ-006 Storage SHALL be flops: tag[SETS][WAYS], valid[SETS][WAYS], and a tree pseudo-LRU of WAYS-1 bits per set.
REQ-007 Lookup compare SHALL be combinational on accept; resp_* SHALL be registered, giving a latency of exactly 1 cycle after accept.
REQ-008 resp_valid SHALL be 1 only in the cycle after an accept and 0 otherwise.
REQ-009 A way hits when valid is set and the tag matches; on multiple hits the lowest-numbered way SHALL win.
REQ-010 resp_victim SHALL be the lowest-numbered invalid way in the set; if all ways are valid, it SHALL be the PLRU-pointed way, evaluated before the same-edge PLRU update.
REQ-011 A hit SHALL update that set's PLRU at the accept edge so the hit way becomes MRU; a miss SHALL leave PLRU unchanged.
REQ-012 A fill SHALL write tag, set valid and make fill_way MRU at the next edge; fills are always accepted when not busy and no handshake is required.
REQ-013 An invalidate SHALL clear valid only; tag and PLRU are unchanged.
REQ-014 A lookup SHALL observe array state before same-edge fill or invalidate writes; no bypass is provided.
REQ-015 For fill and hit in the same set on the same edge, the fill PLRU update SHALL take precedence.
REQ-016 For fill and invalidate to the same set and way on the same edge, invalidate SHALL win: valid = 0 and tag is written.
REQ-017 FSM states SHALL be IDLE and FLUSH.
- IDLE -> FLUSH on flush_start; the counter loads 0.
- In FLUSH, each cycle clears valid and PLRU of set[counter] and increments the counter.
- When counter == SETS-1, flush_done = 1 and the FSM returns to IDLE.
- The sweep therefore takes exactly SETS cycles.
REQ-018 busy SHALL be 1 exactly while in FLUSH; req_ready SHALL be !busy && !rst.
REQ-019 While busy, fill, inval and flush_start SHALL be ignored.
REQ-020 flush_start asserted together with req_valid in IDLE SHALL accept the lookup (pre-flush state) and enter FLUSH at the same edge.
REQ-021 The counter SHALL be IDX_W bits and SHALL not wrap past SETS-1.

Reset
REQ-022 While rst is high at an edge: all valid = 0, all PLRU = 0, FSM = IDLE, counter = 0, resp_valid/resp_hit/resp_way/resp_victim/flush_done = 0.
REQ-023 Tag contents are don't-care after reset.
REQ-024 rst SHALL take priority over every concurrent input, including a reset asserted mid-flush; the FSM SHALL return to IDLE with all sets invalid.
REQ-025 req_ready SHALL be 0 during rst and 1 in the first cycle after rst deasserts.

Verification (WAYS=4, SETS=8, TAG_W=9)
REQ-026 After reset, lookup idx 3 tag 0x05 -> next cycle resp_valid=1, resp_hit=0, resp_victim=0.
REQ-027 Fill idx 3 ways 0..3 with tags 0x10..0x13, then look up tag 0x12 -> resp_hit=1, resp_way=2; the next lookup of tag 0x1FF at idx 3 returns a victim other than way 2.
REQ-028 Fill idx 5 way 1 tag 0x0A and look up idx 5 tag 0x0A on the same edge -> resp_hit=0; the lookup one cycle later gives resp_hit=1, resp_way=1.
REQ-029 Fill ways 0 and 2 of idx 1 with tag 0x33 -> lookup returns resp_way=0; invalidate way 0 -> lookup returns resp_way=2, resp_victim=0.
REQ-030 flush_start -> busy=1 for 8 cycles, req_ready=0, flush_done pulses on cycle 8; a fill issued during the flush is dropped; every subsequent lookup misses.
REQ-031 rst asserted on flush cycle 4 -> the next cycle shows busy=0, flush_done never pulses, and all sets miss.

Source files
------------

// File: rtl/tag_lookup_nway.sv
// N-way tag directory with per-set tree pseudo-LRU, one-cycle registered lookup,
// fill/invalidate write ports and a set-by-set flush sweep.
module tag_lookup_nway #(
  parameter int WAYS  = 2,
  parameter int SETS  = 8,
  parameter int TAG_W = 9,
  localparam int IDX_W = $clog2(SETS),
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [IDX_W-1:0] req_index,
  input  logic [TAG_W-1:0] req_tag,
  output logic             req_ready,
  output logic             resp_valid,
  output logic             resp_hit,
  output logic [WAY_W-1:0] resp_way,
  output logic [WAY_W-1:0] resp_victim,
  input  logic             fill_valid,
  input  logic [IDX_W-1:0] fill_index,
  input  logic [WAY_W-1:0] fill_way,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic             inval_valid,
  input  logic [IDX_W-1:0] inval_index,
  input  logic [WAY_W-1:0] inval_way,
  input  logic             flush_start,
  output logic             busy,
  output logic             flush_done
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;
  localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(SETS - 1);

  logic [TAG_W-1:0] tag_reg   [SETS][WAYS];
  logic [WAYS-1:0]  valid_reg [SETS];
  logic [WAYS-2:0]  plru_reg  [SETS];
  logic [0:0]       state_reg;
  logic [IDX_W-1:0] count_reg;

  logic             accept, fill_en, inval_en;
  logic [WAYS-1:0]  set_valid, hit_vec;
  logic             hit_any, has_free;
  logic [WAY_W-1:0] hit_way, free_way, victim;

  // Heap-ordered tree: node n has children 2n+1 / 2n+2; a 0 bit points the victim left.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] bits);
    logic [WAY_W-1:0] way;
    int node;
    way  = '0;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      way[WAY_W-1-l] = bits[node];
      node = 2 * node + 1 + (bits[node] ? 1 : 0);
    end
    return way;
  endfunction

  // Every node on the path to the touched way is turned to point away from it.
  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] bits,
                                                 input logic [WAY_W-1:0] way);
    logic [WAYS-2:0] r;
    int node;
    r    = bits;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      r[node] = ~way[WAY_W-1-l];
      node = 2 * node + 1 + (way[WAY_W-1-l] ? 1 : 0);
    end
    return r;
  endfunction

  assign busy       = (state_reg == FLUSH);
  assign req_ready  = !busy && !rst;
  assign flush_done = busy && (count_reg == LAST_SET);
  assign accept     = req_valid && req_ready;
  assign fill_en    = fill_valid && !busy;
  assign inval_en   = inval_valid && !busy;
  assign set_valid  = valid_reg[req_index];

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_cmp
      assign hit_vec[gi] = set_valid[gi] && (tag_reg[req_index][gi] == req_tag);
    end
  endgenerate

  // Downward scans so the lowest-numbered matching / free way is what remains.
  always_comb begin
    hit_any  = |hit_vec;
    has_free = ~&set_valid;
    hit_way  = '0;
    free_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w])    hit_way  = WAY_W'(w);
      if (!set_valid[w]) free_way = WAY_W'(w);
    end
    victim = has_free ? free_way : plru_victim(plru_reg[req_index]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_reg[s] <= '0;
        plru_reg[s]  <= '0;
      end
      state_reg   <= IDLE;
      count_reg   <= '0;
      resp_valid  <= 1'b0;
      resp_hit    <= 1'b0;
      resp_way    <= '0;
      resp_victim <= '0;
    end else begin
      resp_valid <= accept;
      if (accept) begin
        resp_hit    <= hit_any;
        resp_way    <= hit_any ? hit_way : '0;
        resp_victim <= victim;
      end
      if (accept && hit_any)
        plru_reg[req_index] <= plru_touch(plru_reg[req_index], hit_way);
      // Later assignments win: fill PLRU beats hit PLRU, invalidate beats fill valid.
      if (fill_en) begin
        tag_reg[fill_index][fill_way]   <= fill_tag;
        valid_reg[fill_index][fill_way] <= 1'b1;
        plru_reg[fill_index]            <= plru_touch(plru_reg[fill_index], fill_way);
      end
      if (inval_en)
        valid_reg[inval_index][inval_way] <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (flush_start) begin
            state_reg <= FLUSH;
            count_reg <= '0;
          end
        end
        FLUSH: begin
          valid_reg[count_reg] <= '0;
          plru_reg[count_reg]  <= '0;
          if (count_reg == LAST_SET)
            state_reg <= IDLE;
          else
            count_reg <= count_reg + IDX_W'(1);
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tag_lookup_nway.sv
// Randomized and directed checks of tag_lookup_nway (4 ways, 8 sets) against a
// recency-based reference model of the directory.
module tb_tag_lookup_nway;

  localparam int WAYS = 4, SETS = 8, TAG_W = 9, IDX_W = 3, WAY_W = 2;

  logic clk = 1'b0;
  logic rst, req_valid, fill_valid, inval_valid, flush_start;
  logic [IDX_W-1:0] req_index, fill_index, inval_index;
  logic [TAG_W-1:0] req_tag, fill_tag;
  logic [WAY_W-1:0] fill_way, inval_way;
  logic req_ready, resp_valid, resp_hit, busy, flush_done;
  logic [WAY_W-1:0] resp_way, resp_victim;

  tag_lookup_nway #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_index(req_index), .req_tag(req_tag), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way), .resp_victim(resp_victim),
    .fill_valid(fill_valid), .fill_index(fill_index), .fill_way(fill_way), .fill_tag(fill_tag),
    .inval_valid(inval_valid), .inval_index(inval_index), .inval_way(inval_way),
    .flush_start(flush_start), .busy(busy), .flush_done(flush_done)
  );

  always #5 clk = ~clk;

  // Reference model: contents plus, per set, which half was touched last and which
  // way inside each half was touched last (-1 = not known since the last clear).
  logic [TAG_W-1:0] tag_m [SETS][WAYS];
  bit valid_m [SETS][WAYS];
  int last_half [SETS];
  int last_in [SETS][2];
  int mru_m [SETS];
  bit busy_m;
  int cnt_m;

  // Expected response of the lookup accepted at the last edge.
  bit e_valid, e_hit;
  int e_way, e_vic, e_mru;
  int vic_mode;  // 0 exact e_vic, 1 anything but e_mru, 2 unconstrained

  int n_checks = 0;
  int n_pass = 0;

  task automatic forget(input int s);
    last_half[s] = -1;
    last_in[s][0] = -1;
    last_in[s][1] = -1;
    mru_m[s] = -1;
  endtask

  task automatic touch(input int s, input int w);
    last_half[s] = w / 2;
    last_in[s][w / 2] = w % 2;
    mru_m[s] = w;
  endtask

  task automatic idle_inputs();
    req_valid = 0; req_index = '0; req_tag = '0;
    fill_valid = 0; fill_index = '0; fill_way = '0; fill_tag = '0;
    inval_valid = 0; inval_index = '0; inval_way = '0;
    flush_start = 0;
  endtask

  // Applies the current inputs to the model, then advances one clock.
  task automatic cycle();
    bit acc, fen, ien;
    int s, hw, fi, h, o;
    if (rst) begin
      for (int i = 0; i < SETS; i++) begin
        for (int w = 0; w < WAYS; w++) valid_m[i][w] = 0;
        forget(i);
      end
      busy_m = 0;
      cnt_m = 0;
      e_valid = 0;
    end else begin
      acc = req_valid && !busy_m;
      fen = fill_valid && !busy_m;
      ien = inval_valid && !busy_m;
      e_valid = acc;
      if (acc) begin
        s = int'(req_index);
        hw = -1;
        fi = -1;
        for (int w = WAYS - 1; w >= 0; w--) begin
          if (valid_m[s][w] && tag_m[s][w] == req_tag) hw = w;
          if (!valid_m[s][w]) fi = w;
        end
        e_hit = (hw >= 0);
        e_way = e_hit ? hw : 0;
        vic_mode = 2;
        if (fi >= 0) begin
          vic_mode = 0; e_vic = fi;
        end else if (last_half[s] >= 0) begin
          h = last_half[s];
          o = 1 - h;
          if (last_in[s][o] >= 0) begin
            vic_mode = 0; e_vic = o * 2 + (1 - last_in[s][o]);
          end else begin
            vic_mode = 1; e_mru = mru_m[s];
          end
        end
        if (hw >= 0 && !(fen && fill_index == req_index)) touch(s, hw);
      end
      if (fen) begin
        tag_m[fill_index][fill_way] = fill_tag;
        valid_m[fill_index][fill_way] = 1;
        touch(int'(fill_index), int'(fill_way));
      end
      if (ien) valid_m[inval_index][inval_way] = 0;
      if (busy_m) begin
        for (int w = 0; w < WAYS; w++) valid_m[cnt_m][w] = 0;
        forget(cnt_m);
        if (cnt_m == SETS - 1) busy_m = 0;
        else cnt_m++;
      end else if (flush_start) begin
        busy_m = 1;
        cnt_m = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    req_valid = 1; fill_valid = 1; fill_tag = 9'h1AA; flush_start = 1;
    #1;
    n_checks++; if (req_ready !== 1'b0) $display("FAIL reset_ready_low: got %b want 0", req_ready); else n_pass++;
    cycle();
    cycle();
    rst = 0;
    idle_inputs();
    #1;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL reset_ready_high: got %b want 1", req_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (flush_done !== 1'b0) $display("FAIL reset_flush_done: got %b want 0", flush_done); else n_pass++;
    n_checks++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %b want 0", resp_valid); else n_pass++;
    n_checks++; if (resp_hit !== 1'b0) $display("FAIL reset_resp_hit: got %b want 0", resp_hit); else n_pass++;
    n_checks++; if (resp_way !== 2'd0) $display("FAIL reset_resp_way: got %0d want 0", resp_way); else n_pass++;
    n_checks++; if (resp_victim !== 2'd0) $display("FAIL reset_resp_victim: got %0d want 0", resp_victim); else n_pass++;
  endtask

  task automatic test_lookup_miss();
    req_valid = 1; req_index = 3; req_tag = 9'h05;
    cycle();
    idle_inputs();
    n_checks++; if (resp_valid !== 1'b1) $display("FAIL miss_valid: got %b want 1", resp_valid); else n_pass++;
    n_checks++; if (resp_hit !== 1'b0) $display("FAIL miss_hit: got %b want 0", resp_hit); else n_pass++;
    n_checks++; if (resp_victim !== 2'd0) $display("FAIL miss_victim: got %0d want 0", resp_victim); else n_pass++;
    cycle();
    n_checks++; if (resp_valid !== 1'b0) $display("FAIL miss_valid_drop: got %b want 0", resp_valid); else n_pass++;
  endtask

  task automatic test_fill_hit();
    for (int w = 0; w < WAYS; w++) begin
      fill_valid = 1; fill_index = 3; fill_way = WAY_W'(w); fill_tag = 9'h10 + TAG_W'(w);
      cycle();
    end
    idle_inputs();
    req_valid = 1; req_index = 3; req_tag = 9'h12;
    cycle();
    n_checks++; if (resp_hit !== 1'b1) $display("FAIL fill_hit: got %b want 1", resp_hit); else n_pass++;
    n_checks++; if (resp_way !== 2'd2) $display("FAIL fill_hit_way: got %0d want 2", resp_way); else n_pass++;
    req_tag = 9'h1FF;
    cycle();
    idle_inputs();
    n_checks++; if (resp_hit !== 1'b0) $display("FAIL full_miss_hit: got %b want 0", resp_hit); else n_pass++;
    n_checks++; if (resp_victim === 2'd2) $display("FAIL full_victim_not_mru: got %0d want not 2", resp_victim); else n_pass++;
    n_checks++; if (resp_victim !== 2'(e_vic)) $display("FAIL full_victim_plru: got %0d want %0d", resp_victim, e_vic); else n_pass++;
  endtask

  task automatic test_same_edge();
    fill_valid = 1; fill_index = 5; fill_way = 1; fill_tag = 9'h0A;
    req_valid = 1; req_index = 5; req_tag = 9'h0A;
    cycle();
    fill_valid = 0;
    n_checks++; if (resp_hit !== 1'b0) $display("FAIL same_edge_no_bypass: got %b want 0", resp_hit); else n_pass++;
    cycle();
    idle_inputs();
    n_checks++; if (resp_hit !== 1'b1) $display("FAIL after_fill_hit: got %b want 1", resp_hit); else n_pass++;
    n_checks++; if (resp_way !== 2'd1) $display("FAIL after_fill_way: got %0d want 1", resp_way); else n_pass++;
  endtask

  task automatic test_invalidate();
    fill_valid = 1; fill_index = 1; fill_way = 0; fill_tag = 9'h33;
    cycle();
    fill_way = 2;
    cycle();
    idle_inputs();
    req_valid = 1; req_index = 1; req_tag = 9'h33;
    cycle();
    req_valid = 0;
    n_checks++; if (resp_way !== 2'd0 || resp_hit !== 1'b1) $display("FAIL multi_hit_lowest: got hit %b way %0d want hit 1 way 0", resp_hit, resp_way); else n_pass++;
    inval_valid = 1; inval_index = 1; inval_way = 0;
    cycle();
    idle_inputs();
    req_valid = 1; req_index = 1; req_tag = 9'h33;
    cycle();
    idle_inputs();
    n_checks++; if (resp_way !== 2'd2 || resp_hit !== 1'b1) $display("FAIL inval_hit_way: got hit %b way %0d want hit 1 way 2", resp_hit, resp_way); else n_pass++;
    n_checks++; if (resp_victim !== 2'd0) $display("FAIL inval_victim: got %0d want 0", resp_victim); else n_pass++;
    // Fill and invalidate of the same way on one edge leaves it invalid.
    fill_valid = 1; fill_index = 6; fill_way = 1; fill_tag = 9'h44;
    inval_valid = 1; inval_index = 6; inval_way = 1;
    cycle();
    idle_inputs();
    req_valid = 1; req_index = 6; req_tag = 9'h44;
    cycle();
    idle_inputs();
    n_checks++; if (resp_hit !== 1'b0) $display("FAIL fill_inval_conflict: got %b want 0", resp_hit); else n_pass++;
  endtask

  task automatic test_flush();
    logic [TAG_W-1:0] t;
    fill_valid = 1; fill_index = 4; fill_way = 3; fill_tag = 9'h77;
    cycle();
    idle_inputs();
    flush_start = 1; req_valid = 1; req_index = 3; req_tag = 9'h10;
    cycle();
    flush_start = 0;
    n_checks++; if (resp_valid !== 1'b1 || resp_hit !== 1'b1 || resp_way !== 2'd0)
      $display("FAIL flush_start_lookup: got v%b h%b w%0d want v1 h1 w0", resp_valid, resp_hit, resp_way); else n_pass++;
    for (int k = 1; k <= SETS; k++) begin
      n_checks++; if (busy !== 1'b1) $display("FAIL flush_busy cycle %0d: got %b want 1", k, busy); else n_pass++;
      n_checks++; if (req_ready !== 1'b0) $display("FAIL flush_ready cycle %0d: got %b want 0", k, req_ready); else n_pass++;
      n_checks++; if (flush_done !== (k == SETS)) $display("FAIL flush_done cycle %0d: got %b want %b", k, flush_done, k == SETS); else n_pass++;
      fill_valid = (k == 3); fill_index = 2; fill_way = 0; fill_tag = 9'h55;
      cycle();
      n_checks++; if (resp_valid !== 1'b0) $display("FAIL flush_no_accept cycle %0d: got %b want 0", k, resp_valid); else n_pass++;
    end
    idle_inputs();
    n_checks++; if (busy !== 1'b0 || flush_done !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL flush_end: got busy %b done %b ready %b want 0 0 1", busy, flush_done, req_ready); else n_pass++;
    for (int s = 0; s < SETS; s++) begin
      t = (s == 3) ? 9'h10 : (s == 2) ? 9'h55 : (s == 4) ? 9'h77 : 9'h33;
      req_valid = 1; req_index = IDX_W'(s); req_tag = t;
      cycle();
      n_checks++; if (resp_valid !== 1'b1 || resp_hit !== 1'b0) $display("FAIL post_flush_miss set %0d: got v%b h%b want v1 h0", s, resp_valid, resp_hit); else n_pass++;
    end
    idle_inputs();
  endtask

  task automatic test_flush_reset();
    for (int s = 0; s < SETS; s++) begin
      fill_valid = 1; fill_index = IDX_W'(s); fill_way = 0; fill_tag = 9'h100 + TAG_W'(s);
      cycle();
    end
    idle_inputs();
    flush_start = 1;
    cycle();
    flush_start = 0;
    for (int k = 1; k <= 3; k++) begin
      n_checks++; if (busy !== 1'b1) $display("FAIL flushrst_busy cycle %0d: got %b want 1", k, busy); else n_pass++;
      cycle();
    end
    rst = 1;
    #1;
    n_checks++; if (req_ready !== 1'b0) $display("FAIL flushrst_ready_in_rst: got %b want 0", req_ready); else n_pass++;
    cycle();
    rst = 0;
    #1;
    n_checks++; if (busy !== 1'b0 || flush_done !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL flushrst_after: got busy %b done %b ready %b want 0 0 1", busy, flush_done, req_ready); else n_pass++;
    for (int s = 0; s < SETS; s++) begin
      req_valid = 1; req_index = IDX_W'(s); req_tag = 9'h100 + TAG_W'(s);
      cycle();
      n_checks++; if (resp_hit !== 1'b0 || flush_done !== 1'b0) $display("FAIL flushrst_miss set %0d: got hit %b done %b want 0 0", s, resp_hit, flush_done); else n_pass++;
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 999) < 4);
      req_valid = ($urandom_range(0, 99) < 60);
      req_index = IDX_W'($urandom_range(0, SETS - 1));
      req_tag = TAG_W'($urandom_range(0, 5));
      fill_valid = ($urandom_range(0, 99) < 40);
      fill_index = IDX_W'($urandom_range(0, SETS - 1));
      fill_way = WAY_W'($urandom_range(0, WAYS - 1));
      fill_tag = TAG_W'($urandom_range(0, 5));
      inval_valid = ($urandom_range(0, 99) < 15);
      inval_index = IDX_W'($urandom_range(0, SETS - 1));
      inval_way = WAY_W'($urandom_range(0, WAYS - 1));
      flush_start = ($urandom_range(0, 99) < 2);
      cycle();
      n_checks++; if (resp_valid !== e_valid) $display("FAIL rand_valid cycle %0d: got %b want %b", i, resp_valid, e_valid); else n_pass++;
      if (e_valid) begin
        n_checks++; if (resp_hit !== e_hit) $display("FAIL rand_hit cycle %0d: got %b want %b", i, resp_hit, e_hit); else n_pass++;
        n_checks++; if (resp_way !== 2'(e_way)) $display("FAIL rand_way cycle %0d: got %0d want %0d", i, resp_way, e_way); else n_pass++;
        if (vic_mode == 0) begin
          n_checks++; if (resp_victim !== 2'(e_vic)) $display("FAIL rand_victim cycle %0d: got %0d want %0d", i, resp_victim, e_vic); else n_pass++;
        end else if (vic_mode == 1) begin
          n_checks++; if (resp_victim === 2'(e_mru)) $display("FAIL rand_victim_mru cycle %0d: got %0d want not %0d", i, resp_victim, e_mru); else n_pass++;
        end
      end
      n_checks++; if (busy !== busy_m) $display("FAIL rand_busy cycle %0d: got %b want %b", i, busy, busy_m); else n_pass++;
      n_checks++; if (flush_done !== (busy_m && cnt_m == SETS - 1)) $display("FAIL rand_done cycle %0d: got %b want %b", i, flush_done, busy_m && cnt_m == SETS - 1); else n_pass++;
      n_checks++; if (req_ready !== (!busy_m && !rst)) $display("FAIL rand_ready cycle %0d: got %b want %b", i, req_ready, !busy_m && !rst); else n_pass++;
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    for (int s = 0; s < SETS; s++) forget(s);
    test_reset();
    test_lookup_miss();
    test_fill_hit();
    test_same_edge();
    test_invalidate();
    test_flush();
    test_flush_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
